ace_txn_ctrl: RTL and testbench

Parametrised ACE master-side transaction controller between the cache datapath and the coherent interconnect. It issues ReadShared, MakeUnique and WriteClean transactions as multi-beat bursts, retries any transaction that ends with a non-OKAY response up to a bounded count, and signals an error when retries run out. It serves incoming snoops on the AC/CR/CD channels through an independent snoop engine, so snoops are handled while a request transaction is in flight.

---
 rtl/ace_txn_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_ace_txn_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_txn_ctrl.sv
// ace_txn_ctrl: ACE master-side transaction controller. The request engine issues
// ReadShared / MakeUnique / WriteClean bursts with bounded retry on non-OKAY
// completion. A separate snoop engine serves AC/CR/CD and runs concurrently.
module ace_txn_ctrl #(
  parameter int BURST_LEN = 4,
  parameter int MAX_RETRY = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic read_req,
  input  logic write_req,
  input  logic invalid_req,
  output logic ace_ready,
  output logic req_error,
  input  logic B_okay,
  input  logic R_okay,
  input  logic snoop_miss,
  input  logic response,
  input  logic response_data,
  output logic read_shared_o,
  output logic make_unique_o,
  output logic write_clean_o,
  output logic read_resp_en,
  output logic ac_enable,
  output logic AR_VALID,
  input  logic AR_READY,
  input  logic R_VALID,
  input  logic R_LAST,
  output logic R_READY,
  output logic AW_VALID,
  input  logic AW_READY,
  output logic W_VALID,
  output logic W_LAST,
  input  logic W_READY,
  input  logic B_VALID,
  output logic B_READY,
  input  logic AC_VALID,
  output logic AC_READY,
  output logic CR_VALID,
  input  logic CR_READY,
  output logic CD_VALID,
  output logic CD_LAST,
  input  logic CD_READY
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST_LEN - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} req_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LOOK, S_CR, S_CD} snp_state_t;

  req_state_t       req_state, req_state_n;
  snp_state_t       snp_state, snp_state_n;
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] cd_q;
  logic [3:0]       retry_q;
  logic             berr_q;
  logic             has_data_q;
  logic             typ_rd_q, typ_inv_q, typ_wr_q;

  logic acc_rd, acc_inv, acc_wr, accept;
  logic retry, give_up, done, beat_adv;
  logic look_done, cd_adv;

  assign accept        = acc_rd | acc_inv | acc_wr;
  assign read_shared_o = typ_rd_q;
  assign make_unique_o = typ_inv_q;
  assign write_clean_o = typ_wr_q;

  // Request engine: next state, per-state channel outputs and counter strobes.
  always_comb begin
    req_state_n  = req_state;
    acc_rd       = 1'b0;
    acc_inv      = 1'b0;
    acc_wr       = 1'b0;
    retry        = 1'b0;
    give_up      = 1'b0;
    done         = 1'b0;
    beat_adv     = 1'b0;
    ace_ready    = 1'b0;
    AR_VALID     = 1'b0;
    R_READY      = 1'b0;
    AW_VALID     = 1'b0;
    W_VALID      = 1'b0;
    W_LAST       = 1'b0;
    B_READY      = 1'b0;
    read_resp_en = 1'b0;
    unique case (req_state)
      IDLE: begin
        ace_ready = 1'b1;
        // Priority write > read > invalidate; losers are simply dropped.
        if (write_req) begin
          acc_wr      = 1'b1;
          req_state_n = AW;
        end else if (read_req) begin
          acc_rd      = 1'b1;
          req_state_n = AR;
        end else if (invalid_req) begin
          acc_inv     = 1'b1;
          req_state_n = AR;
        end
      end
      AR: begin
        AR_VALID = 1'b1;
        if (AR_READY) req_state_n = R;
      end
      R: begin
        R_READY      = 1'b1;
        read_resp_en = R_VALID & R_okay;
        if (R_VALID && R_LAST) begin
          // The last beat's own status counts toward the burst verdict.
          if (!berr_q && R_okay) begin
            done        = 1'b1;
            req_state_n = IDLE;
          end else if (retry_q < RETRY_LIMIT) begin
            retry       = 1'b1;
            req_state_n = AR;
          end else begin
            give_up     = 1'b1;
            done        = 1'b1;
            req_state_n = IDLE;
          end
        end
      end
      AW: begin
        AW_VALID = 1'b1;
        if (AW_READY) req_state_n = W;
      end
      W: begin
        W_VALID = 1'b1;
        W_LAST  = (beat_q == LAST_BEAT);
        if (W_READY) begin
          beat_adv = 1'b1;
          if (W_LAST) req_state_n = B;
        end
      end
      B: begin
        B_READY = 1'b1;
        if (B_VALID) begin
          if (B_okay) begin
            done        = 1'b1;
            req_state_n = IDLE;
          end else if (retry_q < RETRY_LIMIT) begin
            retry       = 1'b1;
            req_state_n = AW;
          end else begin
            give_up     = 1'b1;
            done        = 1'b1;
            req_state_n = IDLE;
          end
        end
      end
      default: req_state_n = IDLE;
    endcase
  end

  // Request engine state, beat/retry counters, sticky burst error and type flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_state <= IDLE;
      beat_q    <= '0;
      retry_q   <= '0;
      berr_q    <= 1'b0;
      req_error <= 1'b0;
      typ_rd_q  <= 1'b0;
      typ_inv_q <= 1'b0;
      typ_wr_q  <= 1'b0;
    end else begin
      req_state <= req_state_n;
      req_error <= give_up;
      if (accept) retry_q <= '0;
      else if (retry) retry_q <= retry_q + 4'd1;
      if (accept || retry || done) berr_q <= 1'b0;
      else if (req_state == R && R_VALID && !R_okay) berr_q <= 1'b1;
      if (accept) beat_q <= '0;
      else if (beat_adv) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
      // Type flags persist across retries and drop only on the return to idle.
      if (done) begin
        typ_rd_q  <= 1'b0;
        typ_inv_q <= 1'b0;
        typ_wr_q  <= 1'b0;
      end else begin
        if (acc_rd)  typ_rd_q  <= 1'b1;
        if (acc_inv) typ_inv_q <= 1'b1;
        if (acc_wr)  typ_wr_q  <= 1'b1;
      end
    end
  end

  // Snoop engine: next state and per-state AC/CR/CD outputs.
  always_comb begin
    snp_state_n = snp_state;
    look_done   = 1'b0;
    cd_adv      = 1'b0;
    AC_READY    = 1'b0;
    ac_enable   = 1'b0;
    CR_VALID    = 1'b0;
    CD_VALID    = 1'b0;
    CD_LAST     = 1'b0;
    unique case (snp_state)
      S_IDLE: begin
        AC_READY = 1'b1;
        if (AC_VALID) snp_state_n = S_LOOK;
      end
      S_LOOK: begin
        ac_enable = 1'b1;
        if (snoop_miss || response) begin
          look_done   = 1'b1;
          snp_state_n = S_CR;
        end
      end
      S_CR: begin
        CR_VALID = 1'b1;
        if (CR_READY) snp_state_n = has_data_q ? S_CD : S_IDLE;
      end
      S_CD: begin
        CD_VALID = 1'b1;
        CD_LAST  = (cd_q == LAST_BEAT);
        if (CD_READY) begin
          cd_adv = 1'b1;
          if (CD_LAST) snp_state_n = S_IDLE;
        end
      end
      default: snp_state_n = S_IDLE;
    endcase
  end

  // Snoop engine state, dirty-data flag and CD beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snp_state  <= S_IDLE;
      has_data_q <= 1'b0;
      cd_q       <= '0;
    end else begin
      snp_state <= snp_state_n;
      // A miss never carries data, whatever the other lookup bits say.
      if (look_done) begin
        has_data_q <= response & response_data & ~snoop_miss;
        cd_q       <= '0;
      end else if (cd_adv) begin
        cd_q <= (cd_q == LAST_BEAT) ? '0 : cd_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ace_txn_ctrl.sv
// Bench for ace_txn_ctrl: request-priority vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_ace_txn_ctrl;
  localparam int BL = 4;
  localparam int MR = 7;

  localparam logic [16:0] O_RDY = 17'h10000, O_ERR = 17'h08000, O_RS  = 17'h04000,
                          O_MU  = 17'h02000, O_WC  = 17'h01000, O_RRE = 17'h00800,
                          O_ACEN= 17'h00400, O_ARV = 17'h00200, O_RR  = 17'h00100,
                          O_AWV = 17'h00080, O_WV  = 17'h00040, O_WL  = 17'h00020,
                          O_BR  = 17'h00010, O_ACR = 17'h00008, O_CRV = 17'h00004,
                          O_CDV = 17'h00002, O_CDL = 17'h00001;
  localparam logic [16:0] RST_OUTS = O_RDY | O_ACR;

  logic clk = 1'b0;
  logic rst_n;
  logic read_req, write_req, invalid_req, B_okay, R_okay;
  logic snoop_miss, response, response_data;
  logic AR_READY, R_VALID, R_LAST, AW_READY, W_READY, B_VALID;
  logic AC_VALID, CR_READY, CD_READY;
  logic ace_ready, req_error, read_shared_o, make_unique_o, write_clean_o;
  logic read_resp_en, ac_enable, AR_VALID, R_READY, AW_VALID, W_VALID, W_LAST;
  logic B_READY, AC_READY, CR_VALID, CD_VALID, CD_LAST;
  logic [16:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ace_txn_ctrl #(.BURST_LEN(BL), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .ace_ready(ace_ready), .req_error(req_error),
    .B_okay(B_okay), .R_okay(R_okay),
    .snoop_miss(snoop_miss), .response(response), .response_data(response_data),
    .read_shared_o(read_shared_o), .make_unique_o(make_unique_o),
    .write_clean_o(write_clean_o), .read_resp_en(read_resp_en), .ac_enable(ac_enable),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .R_VALID(R_VALID), .R_LAST(R_LAST),
    .R_READY(R_READY), .AW_VALID(AW_VALID), .AW_READY(AW_READY), .W_VALID(W_VALID),
    .W_LAST(W_LAST), .W_READY(W_READY), .B_VALID(B_VALID), .B_READY(B_READY),
    .AC_VALID(AC_VALID), .AC_READY(AC_READY), .CR_VALID(CR_VALID), .CR_READY(CR_READY),
    .CD_VALID(CD_VALID), .CD_LAST(CD_LAST), .CD_READY(CD_READY)
  );

  assign outs = {ace_ready, req_error, read_shared_o, make_unique_o, write_clean_o,
                 read_resp_en, ac_enable, AR_VALID, R_READY, AW_VALID, W_VALID, W_LAST,
                 B_READY, AC_READY, CR_VALID, CD_VALID, CD_LAST};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read_req = 0; write_req = 0; invalid_req = 0; B_okay = 0; R_okay = 0;
    snoop_miss = 0; response = 0; response_data = 0;
    AR_READY = 0; R_VALID = 0; R_LAST = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
    AC_VALID = 0; CR_READY = 0; CD_READY = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_kind;    // 0 none, 1 ReadShared, 2 MakeUnique, 3 WriteClean
  int m_phase;   // 0 address, 1 data, 2 write response
  int m_beats, m_fails;
  bit m_bad, m_err;
  int s_phase;   // 0 wait AC, 1 lookup, 2 CR, 3 CD
  int s_cd;
  bit s_data;

  task automatic m_init();
    m_kind = 0; m_phase = 0; m_beats = 0; m_fails = 0; m_bad = 0; m_err = 0;
    s_phase = 0; s_cd = 0; s_data = 0;
  endtask

  task automatic m_finish_attempt(input bit ok, input int retry_phase);
    if (ok) m_kind = 0;
    else if (m_fails < MR) begin m_fails++; m_bad = 0; m_phase = retry_phase; end
    else begin m_kind = 0; m_err = 1; end
  endtask

  task automatic model_step();
    m_err = 0;
    if (m_kind == 0) begin
      m_phase = 0; m_beats = 0; m_fails = 0; m_bad = 0;
      if (write_req) m_kind = 3;
      else if (read_req) m_kind = 1;
      else if (invalid_req) m_kind = 2;
    end else if (m_kind == 3) begin
      if (m_phase == 0 && AW_READY) m_phase = 1;
      else if (m_phase == 1 && W_READY) begin
        m_beats++;
        if (m_beats == BL) begin m_beats = 0; m_phase = 2; end
      end else if (m_phase == 2 && B_VALID) m_finish_attempt(B_okay, 0);
    end else begin
      if (m_phase == 0 && AR_READY) m_phase = 1;
      else if (m_phase == 1 && R_VALID) begin
        if (!R_okay) m_bad = 1;
        if (R_LAST) m_finish_attempt(!m_bad, 0);
      end
    end
    case (s_phase)
      0: if (AC_VALID) s_phase = 1;
      1: if (snoop_miss || response) begin
           s_data = response && response_data && !snoop_miss;
           s_phase = 2;
         end
      2: if (CR_READY) begin s_cd = 0; s_phase = s_data ? 3 : 0; end
      default: if (CD_READY) begin s_cd++; if (s_cd == BL) s_phase = 0; end
    endcase
  endtask

  function automatic logic [16:0] model_outs();
    logic [16:0] o;
    bit rd_t, wr_t;
    o = '0;
    rd_t = (m_kind == 1) || (m_kind == 2);
    wr_t = (m_kind == 3);
    if (m_kind == 0) o |= O_RDY;
    if (m_err) o |= O_ERR;
    if (m_kind == 1) o |= O_RS;
    if (m_kind == 2) o |= O_MU;
    if (m_kind == 3) o |= O_WC;
    if (rd_t && m_phase == 0) o |= O_ARV;
    if (rd_t && m_phase == 1) begin
      o |= O_RR;
      if (R_VALID && R_okay) o |= O_RRE;
    end
    if (wr_t && m_phase == 0) o |= O_AWV;
    if (wr_t && m_phase == 1) begin
      o |= O_WV;
      if (m_beats == BL - 1) o |= O_WL;
    end
    if (wr_t && m_phase == 2) o |= O_BR;
    case (s_phase)
      0: o |= O_ACR;
      1: o |= O_ACEN;
      2: o |= O_CRV;
      default: begin
        o |= O_CDV;
        if (s_cd == BL - 1) o |= O_CDL;
      end
    endcase
    return o;
  endfunction

  // ---------------- directed helpers ----------------
  int c_aw, c_w, c_wlast, wlast_at, b_at, c_cr, c_cd, c_cdlast, cdlast_at;
  int c_acen, c_overlap, wc_low, mon_cyc;
  bit mon_timeout;

  task automatic monitor(input int max_cyc);
    c_aw = 0; c_w = 0; c_wlast = 0; wlast_at = 0; b_at = -1; c_cr = 0; c_cd = 0;
    c_cdlast = 0; cdlast_at = 0; c_acen = 0; c_overlap = 0; wc_low = 0;
    mon_cyc = 0; mon_timeout = 0;
    #1;
    while (mon_cyc == 0 || !(ace_ready && AC_READY)) begin
      if (mon_cyc >= max_cyc) begin mon_timeout = 1; break; end
      if (AW_VALID && AW_READY) c_aw++;
      if (W_VALID && W_READY) begin
        c_w++;
        if (W_LAST) begin c_wlast++; wlast_at = c_w; end
      end
      if (B_READY && b_at < 0) b_at = mon_cyc;
      if (!ace_ready && !write_clean_o) wc_low++;
      if (CR_VALID && CR_READY) c_cr++;
      if (CD_VALID && CD_READY) begin
        c_cd++;
        if (CD_LAST) begin c_cdlast++; cdlast_at = c_cd; end
      end
      if (ac_enable) c_acen++;
      if (W_VALID && (ac_enable || CR_VALID || CD_VALID)) c_overlap++;
      tick();
      AC_VALID = 0;
      mon_cyc++;
    end
  endtask

  task automatic drain(input string name, output int ar_seen);
    int n;
    n = 0;
    ar_seen = 0;
    AR_READY = 1; AW_READY = 1; W_READY = 1; R_VALID = 1; R_LAST = 1; R_okay = 1;
    B_VALID = 1; B_okay = 1;
    #1;
    while (!ace_ready && n < 40) begin
      if (AR_VALID) ar_seen++;
      tick();
      n++;
    end
    check({name, " drain"}, ace_ready, 1);
    idle_inputs();
  endtask

  task automatic read_run(input bit inv, input int bad_bursts, input bit all_bad,
                          output int ar_hs, output int ok_beats, output int rre_bad,
                          output int type_low, output int err_busy, output bit idle_err,
                          output bit err_next, output bit type_idle, output bit timed_out);
    int burst, beat, cyc;
    burst = 0; beat = 0; cyc = 0;
    ar_hs = 0; ok_beats = 0; rre_bad = 0; type_low = 0; err_busy = 0; timed_out = 0;
    idle_inputs();
    AR_READY = 1;
    R_VALID = 1;
    if (inv) invalid_req = 1; else read_req = 1;
    tick();
    invalid_req = 0;
    read_req = 0;
    forever begin
      R_LAST = (beat == BL - 1);
      R_okay = !(burst < bad_bursts && (all_bad || beat == 1));
      #1;
      if (ace_ready) break;
      if (cyc >= 300) begin timed_out = 1; break; end
      if (AR_VALID && AR_READY) ar_hs++;
      if (read_resp_en !== (R_READY && R_okay)) rre_bad++;
      if (read_resp_en) ok_beats++;
      if (req_error) err_busy++;
      if ((inv ? make_unique_o : read_shared_o) !== 1'b1) type_low++;
      if (R_READY) begin
        if (beat == BL - 1) begin beat = 0; burst++; end
        else beat++;
      end
      tick();
      cyc++;
    end
    idle_err = req_error;
    type_idle = read_shared_o | make_unique_o;
    idle_inputs();
    tick();
    err_next = req_error;
  endtask

  typedef struct {
    logic wr;
    logic rd;
    logic inv;
    logic [16:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int ar_seen, ar_hs, ok_beats, rre_bad, type_low, err_busy, rnd_err;
    bit idle_err, err_next, type_idle, timed_out;
    logic [16:0] exp;

    tbl[0] = '{1'b0, 1'b0, 1'b0, RST_OUTS};
    tbl[1] = '{1'b0, 1'b0, 1'b1, O_MU | O_ARV | O_ACR};
    tbl[2] = '{1'b0, 1'b1, 1'b0, O_RS | O_ARV | O_ACR};
    tbl[3] = '{1'b0, 1'b1, 1'b1, O_RS | O_ARV | O_ACR};
    tbl[4] = '{1'b1, 1'b0, 1'b0, O_WC | O_AWV | O_ACR};
    tbl[5] = '{1'b1, 1'b0, 1'b1, O_WC | O_AWV | O_ACR};
    tbl[6] = '{1'b1, 1'b1, 1'b0, O_WC | O_AWV | O_ACR};
    tbl[7] = '{1'b1, 1'b1, 1'b1, O_WC | O_AWV | O_ACR};

    // Reset state, both during and after reset.
    idle_inputs();
    rst_n = 0;
    #1;
    check("reset_during", outs, RST_OUTS);
    tick();
    tick();
    rst_n = 1;
    tick();
    check("reset_after", outs, RST_OUTS);

    // Request priority table: outputs in the cycle after the request edge.
    for (int i = 0; i < 8; i++) begin
      write_req = tbl[i].wr;
      read_req = tbl[i].rd;
      invalid_req = tbl[i].inv;
      tick();
      write_req = 0; read_req = 0; invalid_req = 0;
      #1;
      check($sformatf("prio_vec%0d", i), outs, tbl[i].exp);
      drain($sformatf("prio_vec%0d", i), ar_seen);
      if (tbl[i].wr) check($sformatf("prio_vec%0d no_ar", i), ar_seen, 0);
      tick();
    end

    // Clean write burst with all READYs high.
    idle_inputs();
    AW_READY = 1; W_READY = 1; B_VALID = 1; B_okay = 1;
    write_req = 1;
    tick();
    write_req = 0;
    monitor(60);
    check("wr timeout", mon_timeout, 0);
    check("wr aw_hs", c_aw, 1);
    check("wr w_beats", c_w, BL);
    check("wr w_last_count", c_wlast, 1);
    check("wr w_last_beat", wlast_at, BL);
    check("wr b_ready_cycle", b_at, BL + 1);
    check("wr type_held", wc_low, 0);
    check("wr type_cleared", write_clean_o, 0);
    check("wr idle_cycle", mon_cyc, BL + 2);
    idle_inputs();
    tick();

    // ReadShared: three bursts fail on beat 2, the fourth is clean.
    read_run(0, 3, 0, ar_hs, ok_beats, rre_bad, type_low, err_busy, idle_err,
             err_next, type_idle, timed_out);
    check("rd_retry timeout", timed_out, 0);
    check("rd_retry ar_hs", ar_hs, 4);
    check("rd_retry okay_beats", ok_beats, 3 * (BL - 1) + BL);
    check("rd_retry resp_en", rre_bad, 0);
    check("rd_retry type_held", type_low, 0);
    check("rd_retry no_error", err_busy + idle_err + err_next, 0);
    check("rd_retry type_cleared", type_idle, 0);

    // MakeUnique with every beat failing: retries run out.
    read_run(1, 1000, 1, ar_hs, ok_beats, rre_bad, type_low, err_busy, idle_err,
             err_next, type_idle, timed_out);
    check("inv_exhaust timeout", timed_out, 0);
    check("inv_exhaust ar_hs", ar_hs, MR + 1);
    check("inv_exhaust okay_beats", ok_beats, 0);
    check("inv_exhaust type_held", type_low, 0);
    check("inv_exhaust err_early", err_busy, 0);
    check("inv_exhaust err_with_ready", idle_err, 1);
    check("inv_exhaust err_one_cycle", err_next, 0);
    check("inv_exhaust type_cleared", type_idle, 0);

    // Dirty snoop arriving while a write burst is in progress.
    idle_inputs();
    AW_READY = 1; W_READY = 1; B_VALID = 1; B_okay = 1;
    CR_READY = 1; CD_READY = 1; response = 1; response_data = 1;
    write_req = 1;
    tick();
    write_req = 0;
    AC_VALID = 1;
    monitor(60);
    check("snp_data timeout", mon_timeout, 0);
    check("snp_data w_beats", c_w, BL);
    check("snp_data w_last_beat", wlast_at, BL);
    check("snp_data lookup_cycles", c_acen, 1);
    check("snp_data cr_hs", c_cr, 1);
    check("snp_data cd_beats", c_cd, BL);
    check("snp_data cd_last_count", c_cdlast, 1);
    check("snp_data cd_last_beat", cdlast_at, BL);
    check("snp_data concurrent", c_overlap > 0, 1);
    idle_inputs();
    tick();

    // Snoop miss: response bits must not produce a data phase.
    CR_READY = 1; CD_READY = 1; snoop_miss = 1; response = 1; response_data = 1;
    AC_VALID = 1;
    monitor(20);
    check("snp_miss timeout", mon_timeout, 0);
    check("snp_miss cr_hs", c_cr, 1);
    check("snp_miss cd_beats", c_cd, 0);
    check("snp_miss lookup_cycles", c_acen, 1);
    idle_inputs();
    tick();

    // Asynchronous reset mid W burst with a CR response stalled.
    AW_READY = 1; snoop_miss = 1; write_req = 1; AC_VALID = 1;
    tick();
    write_req = 0;
    AC_VALID = 0;
    tick();
    tick();
    check("mid_reset pre_w_valid", W_VALID, 1);
    check("mid_reset pre_cr_valid", CR_VALID, 1);
    #1;
    rst_n = 0;
    #1;
    check("mid_reset async", outs, RST_OUTS);
    tick();
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset cycle%0d", i), outs, RST_OUTS);
    end

    // Randomized traffic on every channel against the reference model.
    reset_dut();
    m_init();
    rnd_err = 0;
    for (int i = 0; i < 3000 && rnd_err < 5; i++) begin
      bit late;
      late = (i >= 1500);
      write_req = ($urandom_range(0, 7) == 0);
      read_req = ($urandom_range(0, 5) == 0);
      invalid_req = ($urandom_range(0, 5) == 0);
      AR_READY = ($urandom_range(0, 3) != 0);
      AW_READY = ($urandom_range(0, 3) != 0);
      W_READY = ($urandom_range(0, 3) != 0);
      R_VALID = ($urandom_range(0, 3) != 0);
      R_LAST = ($urandom_range(0, 2) == 0);
      R_okay = late ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
      B_VALID = ($urandom_range(0, 1) == 0);
      B_okay = late ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
      AC_VALID = ($urandom_range(0, 3) == 0);
      snoop_miss = ($urandom_range(0, 4) == 0);
      response = ($urandom_range(0, 4) == 0);
      response_data = ($urandom_range(0, 1) == 0);
      CR_READY = ($urandom_range(0, 2) != 0);
      CD_READY = ($urandom_range(0, 3) != 0);
      #1;
      exp = model_outs();
      checks++;
      if (outs !== exp) begin
        errors++;
        rnd_err++;
        $display("FAIL random cycle %0d: outs=%05h, expected %05h", i, outs, exp);
      end
      tick();
      model_step();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
